// File: rtl/uart_tx_periph.sv
// APB3 UART transmitter: CTRL/STATUS/TXDATA/BAUDDIV registers, a small TX FIFO
// and an 8N1 serialiser. One wait state per APB transfer.
module uart_tx_periph #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        tx
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    tx_state_e     state_q, state_d;
    logic          tx_q, tx_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   div_q, div_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;

    logic          en_q, en_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   bauddiv_q, bauddiv_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic          pready_q, pready_d;
    logic [31:0]   prdata_q, prdata_d;

    logic          access;
    logic          wr_fire;
    logic [1:0]    addr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          busy;
    logic          start_frame;
    logic          push_req;
    logic          push_ok;

    logic          unused_ok;
    assign unused_ok = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

    assign access      = PSEL & PENABLE;
    assign wr_fire     = access & pready_q & PWRITE;
    assign addr        = PADDR[3:2];
    assign fifo_full   = (count_q == DEPTH_C);
    assign fifo_empty  = (count_q == '0);
    assign busy        = (state_q != S_IDLE);
    assign start_frame = (state_q == S_IDLE) & en_q & ~fifo_empty;
    assign push_req    = wr_fire & (addr == 2'd2);
    // A full FIFO still accepts a push when the transmitter pops in the same cycle.
    assign push_ok     = push_req & (~fifo_full | start_frame);

    // APB response, register file and FIFO bookkeeping
    always_comb begin
        pready_d  = access & ~pready_q;
        prdata_d  = '0;
        en_d      = en_q;
        ovf_d     = ovf_q;
        bauddiv_d = bauddiv_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (access & ~pready_q & ~PWRITE) begin
            case (addr)
                2'd0:    prdata_d = {31'd0, en_q};
                2'd1:    prdata_d = {28'd0, ovf_q, busy, fifo_empty, fifo_full};
                2'd3:    prdata_d = {16'd0, bauddiv_q};
                default: prdata_d = '0;
            endcase
        end

        if (wr_fire) begin
            case (addr)
                2'd0: en_d = PWDATA[0];
                2'd1: if (PWDATA[3]) ovf_d = 1'b0;
                2'd3: bauddiv_d = PWDATA[15:0];
                default: ;
            endcase
        end

        if (push_req & ~push_ok) begin
            ovf_d = 1'b1;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (start_frame) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, start_frame})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Transmitter: each bit holds for div_q+1 cycles via a down-counter
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (start_frame) begin
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    shreg_d   = fifo_mem[rd_ptr_q];
                    div_d     = bauddiv_q;
                    cnt_d     = bauddiv_q;
                    bit_idx_d = '0;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d   = S_DATA;
                    cnt_d     = div_q;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shreg_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    state_d   = S_IDLE;
                    tx_d      = 1'b1;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            bauddiv_q <= DIV_RESET;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            bauddiv_q <= bauddiv_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by count_q
    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= PWDATA[7:0];
        end
    end

    assign PREADY = pready_q;
    assign PRDATA = prdata_q;
    assign tx     = tx_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: APB register access, frame shape,
// FIFO overflow, EN-clear mid-frame and asynchronous reset mid-frame.
module tb_uart_tx_periph;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_TXDATA = 32'h8;
    localparam logic [31:0] A_BAUD   = 32'hC;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        tx;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] rd;
    logic [31:0] rd_mid;
    logic [63:0] fs;
    int unsigned fn;

    uart_tx_periph #(.FIFO_DEPTH(4), .DIV_RESET(16'd867)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .tx      (tx)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        int unsigned n;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        do begin @(posedge PCLK); #1; n++; end while (PREADY !== 1'b1 && n < 8);
        check("wr_ready_latency", n, 1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        check("wr_ready_drop", PREADY, 0);
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        int unsigned n;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        check("rd_prdata_before_ready", PRDATA, 0);
        n = 0;
        do begin @(posedge PCLK); #1; n++; end while (PREADY !== 1'b1 && n < 8);
        check("rd_ready_latency", n, 1);
        d = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        check("rd_ready_drop", PREADY, 0);
        check("rd_prdata_after", PRDATA, 0);
    endtask

    // Sample tx once per cycle from the first low sample; 40 samples = one frame at divisor 3
    task automatic capture_frame(output logic [63:0] s, output int unsigned wait_n);
        s = '0;
        wait_n = 0;
        do begin @(posedge PCLK); #1; wait_n++; end while (tx !== 1'b0 && wait_n < 100);
        s[0] = tx;
        for (int unsigned k = 1; k < 40; k++) begin
            @(posedge PCLK); #1;
            s[k] = tx;
        end
    endtask

    function automatic logic [63:0] frame_exp(input logic [7:0] b);
        logic [63:0] f;
        f = '0;
        for (int unsigned i = 0; i < 8; i++) f[4 + 4*i +: 4] = {4{b[i]}};
        f[39:36] = 4'hF;
        return f;
    endfunction

    task automatic expect_idle(input string tag, input int unsigned cycles);
        int unsigned lows;
        lows = 0;
        repeat (cycles) begin
            @(posedge PCLK); #1;
            if (tx !== 1'b1) lows++;
        end
        check(tag, lows, 0);
    endtask

    initial begin
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        repeat (2) @(posedge PCLK); #1;
        check("rst_tx", tx, 1);
        check("rst_pready", PREADY, 0);
        check("rst_prdata", PRDATA, 0);
        PRESET = 1'b1;

        apb_read(A_STATUS, rd); check("rst_status", rd, 32'h2);
        apb_read(A_BAUD, rd);   check("rst_bauddiv", rd, 32'd867);
        apb_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
        apb_read(A_TXDATA, rd); check("txdata_reads_zero", rd, 32'h0);

        apb_write(A_BAUD, 32'h0001_2345);
        apb_read(A_BAUD, rd);   check("bauddiv_16bit", rd, 32'h2345);

        // Single 0xA5 frame at divisor 3, BUSY read mid-frame
        apb_write(A_BAUD, 32'd3);
        apb_write(A_CTRL, 32'h1);
        apb_read(A_CTRL, rd);   check("ctrl_en", rd, 32'h1);
        apb_write(A_TXDATA, 32'hFFFF_FFA5);
        fork
            capture_frame(fs, fn);
            begin
                repeat (10) @(posedge PCLK);
                apb_read(A_STATUS, rd_mid);
            end
        join
        check("a5_start_latency", fn, 1);
        check("a5_frame", fs, frame_exp(8'hA5));
        check("a5_status_busy", rd_mid, 32'h6);
        apb_read(A_STATUS, rd); check("a5_status_after", rd, 32'h2);

        // Overflow: five pushes into a four-entry FIFO with EN off
        apb_write(A_CTRL, 32'h0);
        for (int unsigned i = 1; i <= 5; i++) apb_write(A_TXDATA, i);
        apb_read(A_STATUS, rd); check("ovf_status", rd, 32'h9);
        apb_write(A_CTRL, 32'h1);
        for (int unsigned i = 0; i < 4; i++) begin
            capture_frame(fs, fn);
            check("burst_gap", fn, (i == 0) ? 1 : 2);
            check("burst_frame", fs, frame_exp(8'(i + 1)));
        end
        expect_idle("burst_no_fifth", 60);
        apb_read(A_STATUS, rd); check("ovf_sticky", rd, 32'hA);
        apb_write(A_STATUS, 32'h8);
        apb_read(A_STATUS, rd); check("ovf_cleared", rd, 32'h2);

        // EN cleared during data bit 3: frame completes, second byte stays queued
        apb_write(A_CTRL, 32'h0);
        apb_write(A_TXDATA, 32'h3C);
        apb_write(A_TXDATA, 32'h77);
        apb_write(A_CTRL, 32'h1);
        fork
            capture_frame(fs, fn);
            begin
                repeat (14) @(posedge PCLK);
                apb_write(A_CTRL, 32'h0);
            end
        join
        check("enclr_frame", fs, frame_exp(8'h3C));
        expect_idle("enclr_no_next", 60);
        apb_read(A_STATUS, rd); check("enclr_status", rd, 32'h0);

        // Reset during data bit 3 of 0x77 with 0x55 still queued
        apb_write(A_TXDATA, 32'h55);
        apb_write(A_CTRL, 32'h1);
        fn = 0;
        do begin @(posedge PCLK); #1; fn++; end while (tx !== 1'b0 && fn < 100);
        check("rstmid_start_latency", fn, 1);
        repeat (17) @(posedge PCLK);
        #1;
        check("rstmid_tx_before", tx, 0);
        #2;
        PRESET = 1'b0;
        #1;
        check("rstmid_tx_forced", tx, 1);
        check("rstmid_pready", PREADY, 0);
        check("rstmid_prdata", PRDATA, 0);
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        apb_read(A_STATUS, rd); check("rstmid_status", rd, 32'h2);
        apb_read(A_CTRL, rd);   check("rstmid_ctrl", rd, 32'h0);
        apb_read(A_BAUD, rd);   check("rstmid_bauddiv", rd, 32'd867);
        expect_idle("rstmid_idle", 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
